// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N_CH producer ports, control and one consumer port.
interface stream_mux_rr_if #(
    parameter int N_CH = 4,
    parameter int W    = 4
);
    localparam int SEL_W = $clog2(N_CH);

    logic                mode;
    logic [SEL_W-1:0]    sel;
    logic [N_CH-1:0]     in_valid;
    logic [N_CH*W-1:0]   in_data;
    logic [N_CH-1:0]     in_ready;
    logic                out_valid;
    logic [W-1:0]        out_data;
    logic [SEL_W-1:0]    out_ch;
    logic                out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N_CH:1 stream mux with fixed-select or round-robin arbitration into one registered output stage.
module stream_mux_rr #(
    parameter int N_CH = 4,
    parameter int W    = 4
) (
    input logic            clk,
    input logic            rst,
    stream_mux_rr_if.slave bus
);
    localparam int SEL_W = $clog2(N_CH);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] gnt;
    logic             gnt_vld;
    logic             load;
    logic             xfer;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic [SEL_W-1:0] out_ch_q;
    logic [31:0]      cand;

    assign load = !out_valid_q || bus.out_ready;
    assign xfer = rst && load && gnt_vld;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        if (!bus.mode) begin
            // Out-of-range sel only exists for non-power-of-two N_CH.
            if (32'(bus.sel) < 32'(N_CH) && bus.in_valid[bus.sel]) begin
                gnt     = bus.sel;
                gnt_vld = 1'b1;
            end
        end else begin
            for (int unsigned k = 0; k < 32'(N_CH); k++) begin
                cand = (32'(ptr) + k) % 32'(N_CH);
                if (!gnt_vld && bus.in_valid[SEL_W'(cand)]) begin
                    gnt     = SEL_W'(cand);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        if (xfer) bus.in_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr         <= '0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data[32'(gnt)*W +: W];
                out_ch_q    <= gnt;
                if (bus.mode)
                    ptr <= (32'(gnt) == 32'(N_CH - 1)) ? '0 : gnt + 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed scoreboard bench for stream_mux_rr (N_CH = 4, W = 4).
module tb_stream_mux_rr;
    localparam int N_CH = 4;
    localparam int W    = 4;

    typedef struct {
        logic [W-1:0] d;
        int           ch;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.N_CH(N_CH), .W(W)) bus ();
    stream_mux_rr #(.N_CH(N_CH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    logic [W-1:0] dat [N_CH];
    logic [W-1:0] xdat;
    beat_t        sb [$];
    int           m_ptr  = 0;
    bit           m_ovld = 1'b0;
    int           errors = 0;
    int           checks = 0;

    always_comb
        for (int i = 0; i < N_CH; i++) bus.in_data[i*W +: W] = dat[i];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int mgrant();
        if (bus.mode == 1'b0)
            return bus.in_valid[bus.sel] ? int'(bus.sel) : -1;
        for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (m_ptr + k) % N_CH;
            if (bus.in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Checks the current cycle against the model, then advances one clock.
    task automatic tick();
        int            g;
        bit            load;
        logic [N_CH-1:0] exp_rdy;
        beat_t         b;
        #1;
        load    = !m_ovld || bus.out_ready;
        g       = mgrant();
        exp_rdy = '0;
        if (load && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ovld));
        if (m_ovld) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(sb.size()), 32'(1));
            end else begin
                b = sb[0];
                chk("out_data", 32'(bus.out_data), 32'(b.d));
                chk("out_ch", 32'(bus.out_ch), b.ch);
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
        if (load && g >= 0) begin
            sb.push_back('{dat[g], g});
            if (bus.mode) m_ptr = (g + 1) % N_CH;
            m_ovld = 1'b1;
        end else if (m_ovld && bus.out_ready) begin
            m_ovld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_ovld", 32'(bus.out_valid), 32'(0));
        chk("rst_rdy", 32'(bus.in_ready), 32'(0));
        chk("rst_data", 32'(bus.out_data), 32'(0));
        #1 rst = 1'b1;
        m_ptr  = 0;
        m_ovld = 1'b0;
        sb.delete();
    endtask

    initial begin
        xdat          = 'x;
        dat[0]        = 4'ha;
        dat[1]        = 4'hb;
        dat[2]        = 4'hc;
        dat[3]        = 4'hd;
        bus.mode      = 1'b1;
        bus.sel       = '0;
        bus.in_valid  = '1;
        bus.out_ready = 1'b1;

        // Held reset with every producer valid.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ovld", 32'(bus.out_valid), 32'(0));
        chk("reset_data", 32'(bus.out_data), 32'(0));
        chk("reset_ch", 32'(bus.out_ch), 32'(0));
        chk("reset_rdy", 32'(bus.in_ready), 32'(0));
        rst = 1'b1;
        tick();
        tick();

        // Fixed select, then X data through channel 3.
        bus.mode = 1'b0;
        for (int s = 0; s < N_CH; s++) begin
            bus.sel = 2'(s);
            tick();
            chk("fixed_ch", 32'(bus.out_ch), s);
        end
        dat[3]  = xdat;
        bus.sel = 2'd3;
        tick();
        chk("x_pass", 32'(bus.out_data), 32'(xdat));
        bus.in_valid = '0;
        tick();
        tick();
        dat[3] = 4'hd;

        // Round-robin fairness from a fresh pointer.
        do_reset();
        bus.mode     = 1'b1;
        bus.in_valid = '1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_seq", 32'(bus.out_ch), i % N_CH);
            chk("rr_valid", 32'(bus.out_valid), 32'(1));
        end

        // Sparse requests 4'b1010.
        do_reset();
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sparse_seq", 32'(bus.out_ch), (i % 2 == 0) ? 1 : 3);
        end
        bus.in_valid = '0;
        tick();
        tick();
        chk("sparse_drain", 32'(bus.out_valid), 32'(0));

        // Backpressure: hold ch2 = 7 for three stalled cycles.
        bus.mode     = 1'b0;
        bus.sel      = 2'd2;
        dat[2]       = 4'h7;
        bus.in_valid = 4'b0100;
        tick();
        dat[2]        = 4'h5;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", 32'(bus.out_data), 32'h7);
            chk("stall_ch", 32'(bus.out_ch), 32'(2));
        end
        bus.out_ready = 1'b1;
        tick();
        chk("release_load", 32'(bus.out_data), 32'h5);
        bus.in_valid = '0;
        tick();
        tick();

        // Asynchronous reset while stalled.
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b0100;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = '0;
        tick();
        chk("stall_ovld", 32'(bus.out_valid), 32'(1));
        do_reset();
        bus.in_valid  = '1;
        bus.out_ready = 1'b1;
        tick();
        chk("rr_restart", 32'(bus.out_ch), 32'(0));
        tick();
        chk("rr_next", 32'(bus.out_ch), 32'(1));
        bus.in_valid = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
